// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-word outputs of uart_rx
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and stop-bit error strobe
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_q, wait_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      wait_q  <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      wait_q  <= wait_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    s1_d    = bus.rxd;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // after a bad stop the line must go high once before a new start counts
        if (s2_q) begin
          wait_d = 1'b0;
        end else if (!wait_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!s2_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (s2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            wait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame stimulus for uart_rx against a frame-level event model
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + (DB + 1) * CPB;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.rx_valid || bus.frame_err)) begin
      check("strobe_exclusive", 32'(bus.rx_valid & bus.frame_err), 32'd0);
      obs_q.push_back('{cyc, bus.frame_err, bus.rx_data});
    end
  end

  task automatic idle(input int k);
    bus.rxd = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    int n;
    n = cyc;
    exp_q.push_back('{n + LAT, !stop_ok, stop_ok ? d : last_good});
    if (stop_ok) last_good = d;
    bus.rxd = 1'b0;
    for (int j = 0; j < CPB; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) check("busy_low_at_e1", 32'(bus.busy), 32'd0);
      if (j == 2) check("busy_high_at_e2", 32'(bus.busy), 32'd1);
    end
    for (int i = 0; i < DB; i++) begin
      bus.rxd = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    bus.rxd = stop_ok;
    repeat (CPB) @(posedge clk);
    #1;
    if (!stop_ok) idle(4);
  endtask

  task automatic glitch(input int w);
    bus.rxd = 1'b0;
    repeat (w) @(posedge clk);
    #1;
    bus.rxd = 1'b1;
    repeat (11 - w) @(posedge clk);
    #1;
    check("glitch_busy_dropped", 32'(bus.busy), 32'd0);
    check("glitch_data_kept", 32'(bus.rx_data), 32'(last_good));
    idle(8);
  endtask

  task automatic break_line();
    exp_q.push_back('{cyc + LAT, 1'b1, last_good});
    bus.rxd = 1'b0;
    repeat (3 * (DB + 2) * CPB) @(posedge clk);
    #1;
    check("break_not_rearmed", 32'(bus.busy), 32'd0);
    idle(5);
  endtask

  task automatic reset_mid_frame(input logic [7:0] d);
    bus.rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rxd = d[i];
      repeat ((i == 4) ? 5 : CPB) @(posedge clk);
    end
    #4;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    last_good = 8'h00;
    bus.rxd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nmin;
    int r;
    bus.rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_ferr", 32'(bus.frame_err), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    idle(5);

    send_frame(8'h65, 1'b1);
    idle(10);
    glitch(4);
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b1);
    idle(3);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    break_line();
    reset_mid_frame(8'h5A);
    send_frame(8'h81, 1'b1);
    send_frame(8'h65, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) glitch($urandom_range(1, 4));
      else send_frame(8'($urandom_range(0, 255)), r != 1);
      idle($urandom_range(0, 6));
    end
    idle(200);

    check("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("ev%0d_cycle", i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      check($sformatf("ev%0d_kind", i), 32'(obs_q[i].err), 32'(exp_q[i].err));
      check($sformatf("ev%0d_data", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
